mem_access_unit: RTL and testbench

Load/store sequencer for the multicycle CPU. Accepts one memory operation from the control unit, drives the word-wide data-memory port through a request/ready handshake, aligns and sign/zero-extends load data, and presents a 32-bit result that the memory data register captures. Stores are issued with byte enables. There is no read-modify-write.

---
 rtl/mem_access_pkg.sv | 75 +++++++
 rtl/mem_access_unit_load_extend.sv | 37 +++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store sequencer.
// Size codes, FSM states and lane/byte-enable helpers.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_e;

    // Lane with the bits below the access size forced to zero.
    function automatic logic [1:0] eff_lane(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [1:0] r;
        unique case (size)
            SZ_BYTE: r = lane;
            SZ_HALF: r = {lane[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic r;
        unique case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = lane[0];
            default: r = (lane != 2'b00);
        endcase
        return r;
    endfunction

    function automatic logic [3:0] be_mask(
        input logic       we,
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] r;
        if (!we) begin
            r = 4'b1111;
        end else begin
            unique case (size)
                SZ_BYTE: r = 4'b0001 << lane;
                SZ_HALF: r = 4'b0011 << {lane[1], 1'b0};
                default: r = 4'b1111;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] lane_data(
        input logic [1:0]  size,
        input logic [31:0] d
    );
        logic [31:0] r;
        unique case (size)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load aligner: picks the addressed byte/half
// from a read word and sign- or zero-extends it to 32 bits.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data_o   = rdata_i;
        unique case (lane_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        unique case (size_i)
            SZ_BYTE:
                data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            SZ_HALF:
                data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            default:
                data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: IDLE -> REQ -> DONE with timeout.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              write,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       ld_q, ld_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       ext_data;
    logic [1:0]        lane_in;

    assign lane_in = eff_lane(size, addr[1:0]);

    load_extend u_ext (
        .rdata_i    (mem_rdata),
        .lane_i     (lane_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ld_d    = ld_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lane_d  = lane_q;
        maddr_d = maddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    we_d    = write;
                    size_d  = size;
                    uns_d   = unsigned_ld;
                    lane_d  = lane_in;
                    maddr_d = {addr[ADDR_W-1:2], 2'b00};
                    be_d    = be_mask(write, size, lane_in);
                    wdata_d = lane_data(size, store_data);
                    cnt_d   = 16'd0;
                    err_d   = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    if (misaligned(size, addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    if (!we_q) ld_d = ext_data;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ld_q    <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            maddr_q <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lane_q  <= lane_d;
            maddr_q <= maddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign error     = done & err_q;
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = maddr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign load_data = ld_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT_CYCLES = 4).
// Follows MEM_ACCESS_MISALIGN_TRAP_EN for the misaligned case.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        unsigned_ld = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        busy, done, error;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int nreq;
    int ndone;

    always #5 clock = ~clock;

    mem_access_unit #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .write(write),
        .size(size),
        .unsigned_ld(unsigned_ld),
        .addr(addr),
        .store_data(store_data),
        .busy(busy),
        .done(done),
        .error(error),
        .load_data(load_data),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] sd);
        write = w;
        size = sz;
        unsigned_ld = u;
        addr = a;
        store_data = sd;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_ld", load_data, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", 32'(mem_be), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        step();
        reset = 1'b0;
        step();

        // word load, ready held high
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("wl_req", 32'(mem_req), 32'd1);
        chk("wl_addr", mem_addr, 32'h10);
        chk("wl_be", 32'(mem_be), 32'hF);
        chk("wl_we", 32'(mem_we), 32'd0);
        step();
        chk("wl_done", 32'(done), 32'd1);
        chk("wl_reqoff", 32'(mem_req), 32'd0);
        chk("wl_err", 32'(error), 32'd0);
        chk("wl_data", load_data, 32'hDEAD_BEEF);
        step();
        chk("wl_idle", 32'(busy), 32'd0);

        // signed / unsigned byte load, lane 3
        mem_rdata = 32'h8012_3456;
        issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
        step();
        chk("sb_data", load_data, 32'hFFFF_FF80);
        step();
        issue(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        step();
        chk("ub_data", load_data, 32'h0000_0080);
        step();

        // signed half load, lane 2
        mem_rdata = 32'hBEEF_1234;
        issue(1'b0, 2'b01, 1'b0, 32'h42, 32'h0);
        step();
        chk("sh_data", load_data, 32'hFFFF_BEEF);
        step();

        // half store at 0x6
        issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_ABCD);
        chk("hs_be", 32'(mem_be), 32'hC);
        chk("hs_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("hs_we", 32'(mem_we), 32'd1);
        chk("hs_addr", mem_addr, 32'h4);
        step();
        chk("hs_done", 32'(done), 32'd1);
        chk("hs_keep", load_data, 32'hFFFF_BEEF);
        step();

        // byte store, lane 1
        issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00CD);
        chk("bs_be", 32'(mem_be), 32'h2);
        chk("bs_wdata", mem_wdata, 32'hCDCD_CDCD);
        chk("bs_addr", mem_addr, 32'h100);
        step();
        step();

        // timeout with a mid-access start
        mem_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        nreq = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (mem_req) nreq++;
            start = (i == 1);
            step();
        end
        start = 1'b0;
        chk("to_nreq", 32'(nreq), 32'd4);
        chk("to_done", 32'(done), 32'd1);
        chk("to_err", 32'(error), 32'd1);
        chk("to_keep", load_data, 32'hFFFF_BEEF);
        step();
        chk("to_idle", 32'(busy), 32'd0);
        step();
        chk("to_noreq", 32'(mem_req), 32'd0);

        // misaligned word load at 0x3
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        issue(1'b0, 2'b10, 1'b0, 32'h3, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        chk("ma_req", 32'(mem_req), 32'd0);
        chk("ma_done", 32'(done), 32'd1);
        chk("ma_err", 32'(error), 32'd1);
        chk("ma_keep", load_data, 32'hFFFF_BEEF);
        step();
`else
        chk("ma_req", 32'(mem_req), 32'd1);
        chk("ma_addr", mem_addr, 32'h0);
        step();
        chk("ma_done", 32'(done), 32'd1);
        chk("ma_err", 32'(error), 32'd0);
        chk("ma_data", load_data, 32'hCAFE_F00D);
        step();
`endif
        chk("ma_idle", 32'(busy), 32'd0);

        // reset during the second REQ cycle
        mem_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        step();
        chk("rm_req2", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rm_req", 32'(mem_req), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) ndone++;
            step();
        end
        chk("rm_nodone", 32'(ndone), 32'd0);
        reset = 1'b0;
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        chk("rr_addr", mem_addr, 32'h44);
        step();
        chk("rr_done", 32'(done), 32'd1);
        chk("rr_data", load_data, 32'h1357_9BDF);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
